// File: rtl/nwc_mem_bridge_pkg.sv
// Shared definitions for the NWC host memory bridge: state encoding,
// default geometry used alongside nwc_top, and accelerator read latency.
package nwc_mem_bridge_pkg;

    localparam int NWC_ADDR_W = 11;
    localparam int NWC_DATA_W = 64;
    localparam int RD_LAT     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } bridge_state_e;

endpackage

// File: rtl/nwc_skid_fifo.sv
// Two-entry valid/ready output buffer; entry d0 is always the head.
module nwc_skid_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] d0, d1;
    logic [1:0]   cnt;
    logic         push, pop;

    assign pop       = out_ready && (cnt != 2'd0);
    assign push      = in_valid && ((cnt != 2'd2) || pop);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = d0;
    assign count     = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d0  <= '0;
            d1  <= '0;
            cnt <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) d0 <= in_data;
                    else             d1 <= in_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        d0 <= in_data;
                    end else begin
                        d0 <= d1;
                        d1 <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nwc_mem_bridge.sv
// Host memory bridge for the NWC accelerator: load A/B banks, serve reads,
// capture byte-enabled results, stream results back. NWC_BRIDGE_PERF_EN adds perf_cycles.
module nwc_mem_bridge
    import nwc_mem_bridge_pkg::*;
#(
    parameter int ADDR_W = NWC_ADDR_W,
    parameter int DATA_W = NWC_DATA_W,
    parameter int WEN_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              acc_start,
    input  logic [ADDR_W-1:0] acc_addr0,
    output logic [DATA_W-1:0] acc_data0,
    input  logic [ADDR_W-1:0] acc_addr1,
    output logic [DATA_W-1:0] acc_data1,
    input  logic [ADDR_W-1:0] acc_addrw,
    input  logic [DATA_W-1:0] acc_wdata,
    input  logic [WEN_W-1:0]  acc_wen,
`ifdef NWC_BRIDGE_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    input  logic              acc_done
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bridge_state_e     state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              s_hs, rd_issue, rd_vld, rd_last, rd_done, pop;
    logic [1:0]        fifo_cnt;
    logic [DATA_W-1:0] rd_r, ram_q0, ram_q1;
    logic [DATA_W:0]   fifo_out;
    logic [RD_LAT-2:0][DATA_W-1:0] out_q0, out_q1;

    logic [DATA_W-1:0] bank_a [DEPTH];
    logic [DATA_W-1:0] bank_b [DEPTH];
    logic [DATA_W-1:0] bank_r [DEPTH];

    assign s_hs = s_valid && s_ready;
    assign pop  = m_valid && m_ready;
    // Count the word in flight from the RAM so the skid FIFO can never overflow.
    assign rd_issue = (state == ST_UNLOAD) && !rd_done &&
                      (({1'b0, fifo_cnt} + {2'b00, rd_vld}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (s_hs) state_nxt = ST_LOAD_A;
            ST_LOAD_A: if (s_hs && cnt == LAST_ADDR) state_nxt = ST_LOAD_B;
            ST_LOAD_B: if (s_hs && cnt == LAST_ADDR) state_nxt = ST_START;
            ST_START:  state_nxt = ST_WAIT;
            ST_WAIT:   if (acc_done) state_nxt = ST_UNLOAD;
            ST_UNLOAD: if (pop && m_last) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            rd_done   <= 1'b0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            acc_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            s_ready   <= state_nxt inside {ST_IDLE, ST_LOAD_A, ST_LOAD_B};
            busy      <= (state_nxt != ST_IDLE);
            acc_start <= (state_nxt == ST_START);
            rd_vld    <= rd_issue;
            rd_last   <= rd_issue && (cnt == LAST_ADDR);
            if (s_hs || rd_issue) cnt <= cnt + 1'b1;
            if (state != ST_UNLOAD)                  rd_done <= 1'b0;
            else if (rd_issue && cnt == LAST_ADDR)   rd_done <= 1'b1;
        end
    end

    // Operand banks: read-first, first read stage is the RAM output register.
    always_ff @(posedge clk) begin
        if (s_hs && state != ST_LOAD_B) bank_a[cnt] <= s_data;
        if (s_hs && state == ST_LOAD_B) bank_b[cnt] <= s_data;
        ram_q0 <= bank_a[acc_addr0];
        ram_q1 <= bank_b[acc_addr1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q0 <= '0;
            out_q1 <= '0;
        end else begin
            out_q0[0] <= ram_q0;
            out_q1[0] <= ram_q1;
            for (int k = 1; k < RD_LAT - 1; k++) begin
                out_q0[k] <= out_q0[k-1];
                out_q1[k] <= out_q1[k-1];
            end
        end
    end

    assign acc_data0 = out_q0[RD_LAT-2];
    assign acc_data1 = out_q1[RD_LAT-2];

    always_ff @(posedge clk) begin
        if (state inside {ST_START, ST_WAIT}) begin
            for (int i = 0; i < WEN_W; i++)
                if (acc_wen[i]) bank_r[acc_addrw][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
        rd_r <= bank_r[cnt];
    end

    nwc_skid_fifo #(.W(DATA_W + 1)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_vld),
        .in_data   ({rd_last, rd_r}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (fifo_out),
        .count     (fifo_cnt)
    );

    assign m_data = fifo_out[DATA_W-1:0];
    assign m_last = m_valid && fifo_out[DATA_W];

`ifdef NWC_BRIDGE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                                       perf_cycles <= '0;
        else if (state == ST_START)                       perf_cycles <= '0;
        else if (state == ST_WAIT && perf_cycles != '1)   perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_nwc_mem_bridge.sv
`timescale 1ns/1ps

module tb_nwc_mem_bridge;
  import nwc_mem_bridge_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int WW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_valid = 1'b0, m_ready = 1'b0, acc_done = 1'b0;
  logic          s_ready, m_valid, m_last, busy, acc_start;
  logic [DW-1:0] s_data, m_data, acc_data0, acc_data1, acc_wdata;
  logic [AW-1:0] acc_addr0, acc_addr1, acc_addrw;
  logic [WW-1:0] acc_wen;
`ifdef NWC_BRIDGE_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  int checks = 0, failures = 0;
  logic [DW-1:0] mA [DEPTH];
  logic [DW-1:0] mB [DEPTH];
  logic [DW-1:0] mR [DEPTH];

  nwc_mem_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .acc_start (acc_start),
    .acc_addr0 (acc_addr0),
    .acc_data0 (acc_data0),
    .acc_addr1 (acc_addr1),
    .acc_data1 (acc_data1),
    .acc_addrw (acc_addrw),
    .acc_wdata (acc_wdata),
    .acc_wen   (acc_wen),
`ifdef NWC_BRIDGE_PERF_EN
    .perf_cycles (perf_cycles),
`endif
    .acc_done  (acc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic load_words(input int n);
    int idx;
    idx = 0;
    for (int guard = 0; guard < 400 && idx < n; guard++) begin
      @(negedge clk);
      chk("load_ready", s_ready, 1'b1);
      if ($urandom_range(3) != 0) begin
        s_valid = 1'b1;
        s_data  = (idx < DEPTH) ? mA[idx] : mB[idx-DEPTH];
        idx++;
      end else begin
        s_valid = 1'b0;
      end
    end
    chk("load_count", idx, n);
  endtask

  task automatic read_phase(input int ncyc, input bit plan);
    logic [AW-1:0] qa[$];
    logic [AW-1:0] qb[$];
    logic [AW-1:0] a0, a1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (qa.size() == RD_LAT) begin
        a0 = qa.pop_front();
        a1 = qb.pop_front();
        chk("rd_a", acc_data0, mA[a0]);
        chk("rd_b", acc_data1, mB[a1]);
      end
      if (plan && c == 0)      begin a0 = AW'(5); a1 = AW'(9);  end
      else if (plan && c == 1) begin a0 = AW'(6); a1 = AW'(10); end
      else if (plan && c == 2) begin a0 = AW'(0); a1 = AW'(0);  end
      else begin
        a0 = AW'($urandom_range(DEPTH-1));
        a1 = AW'($urandom_range(DEPTH-1));
      end
      acc_addr0 = a0;
      acc_addr1 = a1;
      qa.push_back(a0);
      qb.push_back(a1);
    end
  endtask

  task automatic acc_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [WW-1:0] w, input bit upd);
    @(negedge clk);
    acc_addrw = a;
    acc_wdata = d;
    acc_wen   = w;
    if (upd)
      for (int b = 0; b < WW; b++)
        if (w[b]) mR[a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic unload_check();
    int n;
    logic hold;
    logic [DW-1:0] held;
    n = 0;
    hold = 1'b0;
    held = '0;
    @(negedge clk);
    acc_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("first_valid", m_valid, 1'b1);
    for (int c = 0; c < 200 && n < DEPTH; c++) begin
      if (c > 0) @(negedge clk);
      if (hold) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_data", m_data, held);
      end
      if (m_valid) begin
        chk("u_data", m_data, mR[n]);
        chk("u_last", m_last, 1'(n == DEPTH-1));
      end else begin
        chk("u_last_idle", m_last, 1'b0);
      end
      m_ready = (c < 4) ? ((c == 0) || (c == 3)) : 1'($urandom_range(1));
      hold = m_valid && !m_ready;
      held = m_data;
      if (m_valid && m_ready) n++;
    end
    chk("u_count", n, DEPTH);
    @(negedge clk);
    m_ready = 1'b0;
    chk("u_busy_end", busy, 1'b0);
    chk("u_valid_end", m_valid, 1'b0);
    chk("u_ready_end", s_ready, 1'b1);
  endtask

  initial begin
    #500000;
    chk("watchdog", 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [AW-1:0] wa;
    s_data = '0; acc_addr0 = '0; acc_addr1 = '0;
    acc_addrw = '0; acc_wdata = '0; acc_wen = '0;

    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_acc_start", acc_start, 1'b0);
    chk("rst_m_data", m_data, 64'h0);
    chk("rst_acc_data0", acc_data0, 64'h0);
    chk("rst_acc_data1", acc_data1, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      mA[i] = DW'(i);
      mB[i] = DW'(32'h100 + i);
    end
    load_words(2 * DEPTH);
    @(negedge clk);
    s_data = '1;
    chk("start_s_ready", s_ready, 1'b0);
    chk("start_pulse", acc_start, 1'b1);
    chk("start_busy", busy, 1'b1);
    acc_done = 1'b1;
    @(negedge clk);
    s_valid  = 1'b0;
    acc_done = 1'b0;
    chk("start_once", acc_start, 1'b0);
    chk("wait_busy", busy, 1'b1);
    read_phase(20, 1'b1);
    chk("done_in_start_ignored", m_valid, 1'b0);

    for (int a = 0; a < DEPTH; a++) acc_write(AW'(a), rnd64(), '1, 1'b1);
    acc_write(AW'(3), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    acc_write(AW'(3), 64'h0, 8'h0F, 1'b1);
    acc_write(AW'($urandom_range(DEPTH-1)), rnd64(), 8'h00, 1'b1);
    for (int k = 0; k < 6; k++) begin
      wa = AW'($urandom_range(DEPTH-1));
      if (wa == AW'(3)) wa = AW'(4);
      acc_write(wa, rnd64(), WW'($urandom_range(255)), 1'b1);
    end
    @(negedge clk);
    acc_wen  = '0;
    acc_done = 1'b1;
    unload_check();

    for (int k = 0; k < 4; k++)
      acc_write(AW'($urandom_range(DEPTH-1)), rnd64(), '1, 1'b0);
    @(negedge clk);
    acc_wen = '0;

    for (int i = 0; i < DEPTH; i++) begin
      mA[i] = rnd64();
      mB[i] = rnd64();
    end
    load_words(DEPTH + 7);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk("abort_s_ready", s_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_m_valid", m_valid, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      mA[i] = rnd64();
      mB[i] = rnd64();
    end
    load_words(2 * DEPTH);
    @(negedge clk);
    s_valid = 1'b0;
    chk("start2_s_ready", s_ready, 1'b0);
    chk("start2_pulse", acc_start, 1'b1);
    chk("start2_busy", busy, 1'b1);
    read_phase(40, 1'b0);
    acc_done = 1'b1;
    unload_check();
`ifdef NWC_BRIDGE_PERF_EN
    chk("perf_cycles", perf_cycles, 32'd40);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nwc_mem_bridge.md
Name: nwc_mem_bridge

Overview:
- Host-side memory bridge for the NWC accelerator.
- Accepts a streamed host load of two operand polynomials into two operand banks.
- Serves the accelerator's two read ports with fixed 2-cycle latency, pulses start, and captures the accelerator's byte-enabled result writes into a result bank.
- After done, streams the result back to the host over a valid/ready master port.

Parameters:
ADDR_W, 11, word-address width; bank depth DEPTH = 2**ADDR_W.
DATA_W, 64, coefficient-word width; must be a multiple of 8.
WEN_W, DATA_W/8, byte-enable width of the accelerator write port (derived).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous active-low reset.
s_valid  in  1  host load word valid.
s_ready  out  1  bridge can accept a load word.
s_data  in  DATA_W  host load word.
m_valid  out  1  result word valid.
m_ready  in  1  host accepts result word.
m_data  out  DATA_W  result word.
m_last  out  1  marks result word DEPTH-1.
busy  out  1  high in any state except IDLE.
acc_start  out  1  one-cycle start pulse to the accelerator.
acc_addr0  in  ADDR_W  accelerator read address, operand bank A.
acc_data0  out  DATA_W  bank A data, 2 cycles after acc_addr0.
acc_addr1  in  ADDR_W  accelerator read address, operand bank B.
acc_data1  out  DATA_W  bank B data, 2 cycles after acc_addr1.
acc_addrw  in  ADDR_W  accelerator result write address.
acc_wdata  in  DATA_W  accelerator result data.
acc_wen  in  WEN_W  byte write enables; bit i writes bits [8i+7:8i].
acc_done  in  1  accelerator completion.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; counters go to 0.
  - s_ready, m_valid, m_last, busy and acc_start are 0; acc_data0/1 and m_data are 0.
  - RAM contents are not cleared.
  - Reset mid-operation aborts immediately; the next run starts from IDLE.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, UNLOAD.
- s_ready = 1 in IDLE, LOAD_A and LOAD_B; 0 otherwise. s_valid outside these states is ignored.
- IDLE: a load handshake writes A[0], sets cnt=1 and moves to LOAD_A.
- LOAD_A: each handshake writes A[cnt]. At cnt=DEPTH-1 the write is accepted, cnt wraps to 0 and the state moves to LOAD_B.
- LOAD_B: the same pattern fills B[0..DEPTH-1]. The handshake at cnt=DEPTH-1 moves the state to START.
- START: acc_start=1 for exactly one cycle, then WAIT.
- WAIT: acc_done=1 moves the state to UNLOAD. acc_done seen in any other state is ignored.
- Accelerator read path, active in all states:
  - Stage 1 registers the RAM read; stage 2 registers the output.
  - acc_dataX(t+2) = bank X[acc_addrX(t)].
  - Read-during-load returns the old contents (read-first).
- Accelerator write path:
  - Honoured only in START and WAIT.
  - R[acc_addrw] is byte-merged per acc_wen in the same cycle.
  - acc_wen=0 writes nothing.
  - Writes in other states are dropped.
- UNLOAD:
  - Streams R[0..DEPTH-1] in order.
  - The RAM has 1-cycle latency and feeds a 2-entry output skid FIFO, so m_valid/m_data hold stable while m_ready=0.
  - First m_valid appears no later than 2 cycles after entering UNLOAD.
  - Full throughput: 1 word/cycle while m_ready stays high.
  - Reads are issued only when the FIFO will not overflow; no word is skipped or duplicated.
  - m_last=1 with word DEPTH-1. After that handshake the state returns to IDLE and busy drops the next cycle.
- Simultaneous events:
  - An s_valid handshake in the same cycle as the LOAD_B→START transition is the last accepted word.
  - acc_done asserted in the START cycle is ignored.

Optional Feature:
- Macro NWC_BRIDGE_PERF_EN.
- When defined:
  - Adds output port perf_cycles (32 bits).
  - The counter clears in START and increments every WAIT cycle, saturating at 0xFFFFFFFF.
  - It holds its value after WAIT and resets to 0 on rst_n.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - bridge state encoding (IDLE..UNLOAD);
  - default ADDR_W/DATA_W constants used with nwc_top;
  - the read-latency constant (2).
- One sub-module: nwc_skid_fifo, a 2-entry valid/ready output buffer used on the unload path.
- Banks are inferred RAM in the bridge.

Test Plan:
1. ADDR_W=4: stream A[i]=i, B[i]=0x100+i, 32 handshakes. Expect s_ready low after the 32nd, acc_start high exactly 1 cycle, busy=1.
2. In WAIT, drive acc_addr0=5, acc_addr1=9. Expect acc_data0=0x5 and acc_data1=0x109 exactly 2 cycles later; back-to-back addresses yield back-to-back data.
3. Write addrw=3, wdata=0xFFFF_FFFF_FFFF_FFFF, wen=0xFF; then addrw=3, wdata=0, wen=0x0F; then acc_done. Expect unloaded R[3]=0xFFFF_FFFF_0000_0000.
4. Unload with m_ready toggling 1,0,0,1 (random 50%). Expect 16 words in order 0..15, data stable while stalled, m_last only on word 15, then IDLE.
5. Assert rst_n=0 during LOAD_B at cnt=7. Expect s_ready=0 and busy=0 next cycle; a fresh 32-word load then runs correctly.
6. With NWC_BRIDGE_PERF_EN, acc_done 40 cycles after acc_start. Expect perf_cycles=40; writes in IDLE are dropped (R unchanged).
